// File: rtl/z_mul_share_arb.sv
// z_mul_share_arb: round-robin front end that lets NREQ requesters share one
// pipelined unsigned multiplier. Issue is combinational. A tag shift register
// runs alongside the multiplier pipeline and routes each product back to the
// requester that issued it, in issue order, as a single-cycle strobe.
module z_mul_share_arb #(
    parameter int  ASIZE   = 37,
    parameter int  BSIZE   = 51,
    parameter int  NREQ    = 3,          // supported range 2..8
    parameter int  MUL_LAT = 2,          // ce-enabled cycles from operand to product
    localparam int PSIZE   = ASIZE + BSIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ASIZE-1:0] req_a,
    input  logic [NREQ*BSIZE-1:0] req_b,
    output logic                  mul_ce,
    output logic [ASIZE-1:0]      mul_a,
    output logic [BSIZE-1:0]      mul_b,
    input  logic [PSIZE-1:0]      mul_p,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [PSIZE-1:0]      rsp_p,
    output logic                  busy
);

    // Width of a requester index, and NREQ at one extra bit so the rotated
    // search index can be wrapped without overflow.
    localparam int          GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW:0] NREQ_W = (GW + 1)'(NREQ);
    localparam logic [GW-1:0] LAST_REQ = GW'(NREQ - 1);

    // One slot of the tag pipeline: does this multiplier stage hold a real
    // operation, and which requester does its product belong to.
    typedef struct packed {
        logic          valid;
        logic [GW-1:0] id;
    } tag_t;

    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    grant_idx;
    logic             grant_any;
    logic             handshake;
    logic [ASIZE-1:0] sel_a;
    logic [BSIZE-1:0] sel_b;
    logic [ASIZE-1:0] held_a;
    logic [BSIZE-1:0] held_b;
    tag_t             tag_in;
    tag_t             tag_pipe [MUL_LAT];
    tag_t             tag_out;
    logic [NREQ-1:0]  tag_onehot;
    logic             pipe_busy;

    // The multiplier follows the global enable so it stays in step with the
    // tag pipeline; both freeze together when ce is low.
    assign mul_ce = ce;

    // Round-robin search: start one past the last granted requester and take
    // the first one with valid operands.
    always_comb begin
        logic [GW:0] cand;
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path leaves a value unassigned and no latch is
        // inferred; clocked blocks use '<=' only.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant} + (GW + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_any && req_valid[cand[GW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[GW-1:0];
            end
        end
    end

    // A grant is only offered when the pipeline can move and reset is idle,
    // so every offered grant is also a completed handshake.
    assign handshake = ce & ~rst & grant_any;

    // Drive the one-hot ready vector from the winning index.
    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pick the granted requester's operand slices out of the packed buses.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_a = req_a[i*ASIZE +: ASIZE];
                sel_b = req_b[i*BSIZE +: BSIZE];
            end
        end
    end

    // Remember the last issued operands so the multiplier inputs only toggle
    // when a new operation is actually issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_a <= '0;
            held_b <= '0;
        end else if (handshake) begin
            held_a <= sel_a;
            held_b <= sel_b;
        end
    end

    assign mul_a = handshake ? sel_a : held_a;
    assign mul_b = handshake ? sel_b : held_b;

    // Arbitration pointer: moves only on a completed handshake; reset parks it
    // on the last requester so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= LAST_REQ;
        end else if (handshake) begin
            last_grant <= grant_idx;
        end
    end

    assign tag_in.valid = handshake;
    assign tag_in.id    = grant_idx;

    // Tag shift register, advanced in lock-step with the multiplier pipeline;
    // non-issue ce cycles push an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits are reset; the ids are don't-care
            // whenever their valid bit is low, so clearing them buys nothing.
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_pipe[i].valid <= 1'b0;
            end
        end else if (ce) begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[MUL_LAT-1];

    // Decode the tag leaving the pipeline into the requester strobe.
    always_comb begin
        tag_onehot = '0;
        tag_onehot[tag_out.id] = 1'b1;
    end

    // Output stage: capture the product alongside a one-cycle strobe to its
    // owner; the product register holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else if (ce && tag_out.valid) begin
            rsp_valid <= tag_onehot;
            rsp_p     <= mul_p;
        end else begin
            rsp_valid <= '0;
        end
    end

    // Busy while any slot of the tag pipeline is occupied or a result is
    // being presented.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            pipe_busy = pipe_busy | tag_pipe[i].valid;
        end
    end

    assign busy = pipe_busy | (|rsp_valid);

endmodule

// File: tb/tb_z_mul_share_arb.sv
// Testbench for z_mul_share_arb: a behavioural multiplier with MUL_LAT
// ce-enabled stages, plus a scoreboard of outstanding operations that counts
// down ce edges and predicts grants, operands, results and busy every cycle.
module tb_z_mul_share_arb;

    localparam int ASIZE   = 37;
    localparam int BSIZE   = 51;
    localparam int NREQ    = 3;
    localparam int MUL_LAT = 2;
    localparam int PSIZE   = ASIZE + BSIZE;
    localparam int AW      = NREQ * ASIZE;
    localparam int BW      = NREQ * BSIZE;

    logic             clk;
    logic             rst;
    logic             ce;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [AW-1:0]    req_a;
    logic [BW-1:0]    req_b;
    logic             mul_ce;
    logic [ASIZE-1:0] mul_a;
    logic [BSIZE-1:0] mul_b;
    logic [PSIZE-1:0] mul_p;
    logic [NREQ-1:0]  rsp_valid;
    logic [PSIZE-1:0] rsp_p;
    logic             busy;

    z_mul_share_arb #(
        .ASIZE  (ASIZE),
        .BSIZE  (BSIZE),
        .NREQ   (NREQ),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_ce   (mul_ce),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .rsp_valid(rsp_valid),
        .rsp_p    (rsp_p),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: product formed at the operand register, then carried
    // through the remaining stages, every stage gated by mul_ce.
    logic [PSIZE-1:0] mp_pipe [MUL_LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp_pipe[0] <= PSIZE'(mul_a) * PSIZE'(mul_b);
            for (int i = 1; i < MUL_LAT; i++) mp_pipe[i] <= mp_pipe[i-1];
        end
    end
    assign mul_p = mp_pipe[MUL_LAT-1];

    // Scoreboard state.
    typedef struct {
        int               tag;
        logic [PSIZE-1:0] p;
        int               cnt;   // ce edges still needed before the strobe shows
    } pend_t;

    pend_t            pend[$];
    int               m_ptr;
    logic [NREQ-1:0]  m_rsp_valid;
    logic [PSIZE-1:0] m_rsp_p;
    logic [ASIZE-1:0] m_last_a;
    logic [BSIZE-1:0] m_last_b;

    int n_tests;
    int n_fail;

    logic [NREQ-1:0]  obs_ready;
    logic [NREQ-1:0]  obs_rsp_valid;
    logic [PSIZE-1:0] obs_rsp_p;
    logic             obs_busy;

    logic [AW-1:0] va;
    logic [BW-1:0] vb;

    function automatic logic [AW-1:0] rand_a();
        logic [AW-1:0] v;
        v = '0;
        for (int i = 0; i < (AW + 31) / 32; i++) v = (v << 32) | AW'($urandom);
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_b();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < (BW + 31) / 32; i++) v = (v << 32) | BW'($urandom);
        return v;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = (r < 0) ? i : -2;
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational issue side, advance the scoreboard at the rising edge,
    // then check the registered outputs.
    task automatic tick(input logic [NREQ-1:0] v, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, input logic c, input logic r);
        int               g;
        int               idx;
        logic [NREQ-1:0]  exp_ready;
        logic [ASIZE-1:0] ea;
        logic [BSIZE-1:0] eb;
        logic [PSIZE-1:0] pa;
        logic [PSIZE-1:0] pb;
        logic             exp_busy;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        ce        = c;
        rst       = r;
        #1;
        g = -1;
        if (!r && c) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = req_ready;
        n_tests++;
        if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ready: got %b expected %b (t=%0t)", req_ready, exp_ready, $time);
        end
        n_tests++;
        if (mul_ce !== c) begin
            n_fail++;
            $display("FAIL mul_ce: got %b expected %b", mul_ce, c);
        end
        ea = m_last_a;
        eb = m_last_b;
        if (g >= 0) begin
            ea = a[g*ASIZE +: ASIZE];
            eb = b[g*BSIZE +: BSIZE];
        end
        if (!r) begin
            n_tests++;
            if (mul_a !== ea || mul_b !== eb) begin
                n_fail++;
                $display("FAIL operands: got a=%h b=%h expected a=%h b=%h", mul_a, mul_b, ea, eb);
            end
        end
        @(posedge clk);
        if (r) begin
            pend.delete();
            m_ptr       = NREQ - 1;
            m_rsp_valid = '0;
            m_rsp_p     = '0;
            m_last_a    = '0;
            m_last_b    = '0;
        end else begin
            m_rsp_valid = '0;
            if (c) begin
                for (int i = 0; i < pend.size(); i++) pend[i].cnt--;
                if (pend.size() > 0 && pend[0].cnt == 0) begin
                    m_rsp_valid = '0;
                    m_rsp_valid[pend[0].tag] = 1'b1;
                    m_rsp_p = pend[0].p;
                    void'(pend.pop_front());
                end
                if (g >= 0) begin
                    pa = PSIZE'(ea);
                    pb = PSIZE'(eb);
                    pend.push_back('{tag: g, p: pa * pb, cnt: MUL_LAT});
                    m_ptr    = g;
                    m_last_a = ea;
                    m_last_b = eb;
                end
            end
        end
        #1;
        obs_rsp_valid = rsp_valid;
        obs_rsp_p     = rsp_p;
        obs_busy      = busy;
        n_tests++;
        if (rsp_valid !== m_rsp_valid) begin
            n_fail++;
            $display("FAIL rsp_valid: got %b expected %b (t=%0t)", rsp_valid, m_rsp_valid, $time);
        end
        n_tests++;
        if (rsp_p !== m_rsp_p) begin
            n_fail++;
            $display("FAIL rsp_p: got %h expected %h (t=%0t)", rsp_p, m_rsp_p, $time);
        end
        exp_busy = (pend.size() > 0) || (m_rsp_valid != '0);
        n_tests++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL busy: got %b expected %b (t=%0t)", busy, exp_busy, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, rand_a(), rand_b(), 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick('1, rand_a(), rand_b(), 1'b1, 1'b1);
        n_tests++;
        if (obs_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", obs_ready);
        end
        n_tests++;
        if (rsp_p !== '0 || mul_a !== '0 || mul_b !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rsp_p=%h mul_a=%h mul_b=%h busy=%b expected all 0",
                     rsp_p, mul_a, mul_b, busy);
        end
        idle(1);
    endtask

    task automatic test_single_op();
        logic [NREQ-1:0] rv [5];
        logic [PSIZE-1:0] rp [5];
        logic             bz [5];
        va = rand_a();
        vb = rand_b();
        va[0 +: ASIZE] = ASIZE'(3);
        vb[0 +: BSIZE] = BSIZE'(5);
        tick(3'b001, va, vb, 1'b1, 1'b0);
        n_tests++;
        if (obs_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 001", obs_ready);
        end
        rv[0] = obs_rsp_valid; rp[0] = obs_rsp_p; bz[0] = obs_busy;
        for (int i = 1; i < 5; i++) begin
            tick('0, rand_a(), rand_b(), 1'b1, 1'b0);
            rv[i] = obs_rsp_valid; rp[i] = obs_rsp_p; bz[i] = obs_busy;
        end
        // Entry i holds the outputs seen in cycle i+1.
        n_tests++;
        if (rv[0] !== '0 || rv[1] !== '0 || rv[2] !== 3'b001 || rv[3] !== '0) begin
            n_fail++;
            $display("FAIL single_timing: got c1=%b c2=%b c3=%b c4=%b expected 000 000 001 000",
                     rv[0], rv[1], rv[2], rv[3]);
        end
        n_tests++;
        if (rp[2] !== PSIZE'(15)) begin
            n_fail++;
            $display("FAIL single_product: got %0d expected 15", rp[2]);
        end
        n_tests++;
        if (bz[0] !== 1'b1 || bz[1] !== 1'b1 || bz[2] !== 1'b1 || bz[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got c1..c4=%b%b%b%b expected 1110", bz[0], bz[1], bz[2], bz[3]);
        end
    endtask

    task automatic test_fairness();
        int grants[$];
        int rsps[$];
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        tick('0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(3'b111, rand_a(), rand_b(), 1'b1, 1'b0);
            grants.push_back(onehot_idx(obs_ready));
            if (obs_rsp_valid != '0) rsps.push_back(onehot_idx(obs_rsp_valid));
        end
        for (int i = 0; i < 4; i++) begin
            tick('0, rand_a(), rand_b(), 1'b1, 1'b0);
            if (obs_rsp_valid != '0) rsps.push_back(onehot_idx(obs_rsp_valid));
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (grants[i] !== exp_order[i]) begin
                n_fail++;
                $display("FAIL fair_grant[%0d]: got %0d expected %0d", i, grants[i], exp_order[i]);
            end
        end
        n_tests++;
        if (rsps.size() !== 6) begin
            n_fail++;
            $display("FAIL fair_rsp_count: got %0d expected 6", rsps.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (rsps[i] !== exp_order[i]) begin
                    n_fail++;
                    $display("FAIL fair_rsp[%0d]: got %0d expected %0d", i, rsps[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            tick(3'b100, rand_a(), rand_b(), 1'b1, 1'b0);
            n_tests++;
            if (obs_ready !== 3'b100) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: got %b expected 100", i, obs_ready);
            end
        end
        idle(4);
    endtask

    task automatic test_ce_stall();
        int rsps[$];
        tick(3'b001, rand_a(), rand_b(), 1'b1, 1'b0);
        tick(3'b010, rand_a(), rand_b(), 1'b1, 1'b0);
        if (obs_rsp_valid != '0) rsps.push_back(onehot_idx(obs_rsp_valid));
        for (int i = 0; i < 4; i++) begin
            tick(3'b111, rand_a(), rand_b(), 1'b0, 1'b0);
            n_tests++;
            if (obs_ready !== '0 || obs_rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL stall_quiet[%0d]: got ready=%b rsp=%b expected 000 000",
                         i, obs_ready, obs_rsp_valid);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick('0, rand_a(), rand_b(), 1'b1, 1'b0);
            if (obs_rsp_valid != '0) rsps.push_back(onehot_idx(obs_rsp_valid));
        end
        n_tests++;
        if (rsps.size() !== 2 || rsps[0] !== 0 || rsps[1] !== 1) begin
            n_fail++;
            $display("FAIL stall_resume: got %0d responses (first=%0d) expected requesters 0 then 1",
                     rsps.size(), (rsps.size() > 0) ? rsps[0] : -1);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        tick(3'b001, rand_a(), rand_b(), 1'b1, 1'b0);
        tick(3'b010, rand_a(), rand_b(), 1'b1, 1'b0);
        tick('0, rand_a(), rand_b(), 1'b1, 1'b1);
        if (obs_rsp_valid != '0) seen++;
        for (int i = 0; i < 5; i++) begin
            tick('0, rand_a(), rand_b(), 1'b1, 1'b0);
            if (obs_rsp_valid != '0) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midflight_discard: got %0d responses expected 0", seen);
        end
        tick(3'b100, rand_a(), rand_b(), 1'b1, 1'b0);
        n_tests++;
        if (obs_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL midflight_req2: got %b expected 100", obs_ready);
        end
        tick(3'b111, rand_a(), rand_b(), 1'b1, 1'b0);
        n_tests++;
        if (obs_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL midflight_wrap: got %b expected 001", obs_ready);
        end
        idle(4);
    endtask

    task automatic test_width_extremes();
        logic [PSIZE-1:0] exp_p;
        logic [PSIZE-1:0] got_p;
        int               found;
        // (2^37-1)*(2^51-1) = 2^88 - 2^51 - 2^37 + 1
        exp_p = PSIZE'(0) - (PSIZE'(1) << 51) - (PSIZE'(1) << 37) + PSIZE'(1);
        va = rand_a();
        vb = rand_b();
        va[1*ASIZE +: ASIZE] = '1;
        vb[1*BSIZE +: BSIZE] = '1;
        found = 0;
        got_p = '0;
        tick(3'b010, va, vb, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick('0, rand_a(), rand_b(), 1'b1, 1'b0);
            if (obs_rsp_valid == 3'b010) begin
                found++;
                got_p = obs_rsp_p;
            end
        end
        n_tests++;
        if (found !== 1 || got_p !== exp_p) begin
            n_fail++;
            $display("FAIL width_extreme: got %0d strobes p=%h expected 1 strobe p=%h", found, got_p, exp_p);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        logic            c;
        logic            r;
        for (int i = 0; i < 500; i++) begin
            v = NREQ'($urandom);
            c = ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 96) == 0);
            tick(v, rand_a(), rand_b(), c, r);
        end
        idle(6);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        ce          = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        m_ptr       = NREQ - 1;
        m_rsp_valid = '0;
        m_rsp_p     = '0;
        m_last_a    = '0;
        m_last_b    = '0;

        test_reset();
        test_single_op();
        test_fairness();
        test_back_to_back();
        test_ce_stall();
        test_reset_midflight();
        test_width_extremes();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z_mul_share_arb.md
Z_MUL_SHARE_ARB -- requirements
Module: z_mul_share_arb

Interface
REQ-001 Parameter ASIZE, default 37, multiplier operand A width.
REQ-002 Parameter BSIZE, default 51, multiplier operand B width; PSIZE = ASIZE+BSIZE (88).
REQ-003 Parameter NREQ, default 3, number of requesters (2..8).
REQ-004 Parameter MUL_LAT, default 2, multiplier latency in ce-enabled cycles from operand to product (XY and M registers enabled, P register disabled).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 ce  input  1  global clock enable; low freezes the issue and tag pipeline.
REQ-008 req_valid  input  NREQ  per-requester operand valid.
REQ-009 req_ready  output  NREQ  per-requester grant; at most one bit high.
REQ-010 req_a  input  NREQ*ASIZE  operand A, requester i in bits [i*ASIZE +: ASIZE].
REQ-011 req_b  input  NREQ*BSIZE  operand B, requester i in bits [i*BSIZE +: BSIZE].
REQ-012 mul_ce  output  1  multiplier clock enable; equals ce.
REQ-013 mul_a / mul_b  output  ASIZE / BSIZE  operands to the shared unsigned multiplier.
REQ-014 mul_p  input  PSIZE  multiplier product.
REQ-015 rsp_valid  output  NREQ  one-hot, single-cycle result strobe per requester.
REQ-016 rsp_p  output  PSIZE  registered product, valid when any rsp_valid bit is high.
REQ-017 busy  output  1  high while any operation is in flight.

Function
REQ-018 Issue is combinational: in a cycle with ce=1, req_ready[g]=1 for exactly one granted g when any req_valid is high; otherwise req_ready=0.
REQ-019 Arbitration is round-robin: the search starts at (last_grant+1) mod NREQ, and the first requester with req_valid=1 is granted.
REQ-020 last_grant updates to g only on a handshake (req_valid[g] & req_ready[g]); it holds otherwise.
REQ-021 mul_a/mul_b carry the granted requester's operands during a handshake cycle; otherwise they hold their last issued values, so the multiplier sees no spurious toggling.
REQ-022 Each handshake pushes {valid=1, tag=g} into a MUL_LAT-deep tag shift register; non-issue ce cycles push {valid=0}.
REQ-023 The tag shift register advances only when ce=1; when ce=0 it holds every entry.
REQ-024 The output stage updates every cycle:
  - rsp_valid <= onehot(tag_out) if ce & tag_out.valid, else 0;
  - rsp_p <= mul_p when that condition is true; otherwise rsp_p holds.
REQ-025 Latency: a handshake in ce-cycle n produces rsp_valid in the cycle after the MUL_LAT-th subsequent ce=1 edge. With ce held high, that is cycle n+MUL_LAT+1 (3 cycles by default).
REQ-026 Throughput is one issue per ce=1 cycle; back-to-back issues from any mix of requesters are allowed.
REQ-027 Results return in issue order; there is no response backpressure, and requesters shall accept rsp_valid unconditionally.
REQ-028 busy = OR of all tag-pipeline valid bits OR any rsp_valid bit.
REQ-029 Boundary conditions:
  - A single requester holding req_valid receives a grant every ce cycle.
  - With all requesters asserted, grants rotate 0,1,2,0,...
  - A requester may drop req_valid without a handshake; no state changes.
REQ-030 ce falling while operations are in flight: no result is lost or duplicated, and each result emerges once after ce returns.

Reset
REQ-031 With rst=1 at a clock edge, the block clears all tag valid bits, sets last_grant to NREQ-1 (requester 0 wins first), and sets rsp_valid=0, rsp_p=0, mul_a=0, mul_b=0.
REQ-032 rst has priority over ce; while rst=1, req_ready=0.
REQ-033 Operations in flight at reset are discarded; no rsp_valid appears for them after reset.

Verification
REQ-034 Single op: rst released; req_valid=001, a=3, b=5 in cycle 0 -> req_ready=001 in cycle 0; rsp_valid=001 with rsp_p=15 in cycle 3; busy high cycles 1-3.
REQ-035 Fairness: req_valid=111 held 6 cycles -> grant order 0,1,2,0,1,2; rsp_valid follows the same order 3 cycles later, with correct products.
REQ-036 ce stall: issue ops from req0 and req1 in consecutive cycles, then ce=0 for 4 cycles -> no rsp_valid and req_ready=0 during the stall; each response appears exactly once after ce=1 resumes, in order.
REQ-037 Reset mid-flight: issue 2 ops, assert rst one cycle later -> no rsp_valid thereafter; the next request from req2 alone is granted, and the arbitration pointer restarts at requester 0 priority.
REQ-038 Width extremes: a=2^37-1, b=2^51-1 -> rsp_p=(2^37-1)*(2^51-1) exactly, with no truncation in the 88-bit result.
